// File: rtl/rsa_modexp_ctrl.sv
// rsa_modexp_ctrl: left-to-right square-and-multiply sequencer for the RSA
// modular-exponentiation datapath. Drives the operand mux selects, launches
// the external modular multiplier and commands result write-back. It holds
// no operand data.
//
// Optional feature macro: RSA_MODEXP_SKIP_LEADING_EN
//   defined   -> processing starts at the most significant 1 of the exponent;
//                an all-zero exponent finishes right after INIT.
//   undefined -> every exponent bit is processed, starting at WIDTH-1.
//
// Mux select codes: 00 = one, 01 = base, 10 = result, 11 = zero.

module rsa_modexp_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] exponent,
    input  logic             mul_done,
    output logic [1:0]       sel_x,
    output logic [1:0]       sel_y,
    output logic             mul_start,
    output logic             res_we,
    output logic             res_src,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] SEL_ONE  = 2'b00;
    localparam logic [1:0] SEL_BASE = 2'b01;
    localparam logic [1:0] SEL_RES  = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INIT      = 3'd1,
        ST_SQR_START = 3'd2,
        ST_SQR_WAIT  = 3'd3,
        ST_MUL_START = 3'd4,
        ST_MUL_WAIT  = 3'd5,
        ST_NEXT      = 3'd6,
        ST_DONE      = 3'd7
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] exp_r;
    logic [IDX_W-1:0] idx_r;
    logic [1:0]       sel_x_r;
    logic [1:0]       sel_y_r;
    logic             mul_start_r;
    logic             res_we_r;
    logic             busy_r;
    logic             done_r;
    logic             wait_r;     // high while in SQR_WAIT or MUL_WAIT
    logic             wb_s;       // product write-back this cycle

`ifdef RSA_MODEXP_SKIP_LEADING_EN
    // Position of the most significant set bit (0 when the value is 0).
    function automatic logic [IDX_W-1:0] msb_index(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] pos;
        pos = {IDX_W{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                pos = IDX_W'(i);
            end
        end
        return pos;
    endfunction
`endif

    // Product write-back is the only output that follows mul_done combinationally.
    assign wb_s      = wait_r & mul_done;

    assign sel_x     = sel_x_r;
    assign sel_y     = sel_y_r;
    assign mul_start = mul_start_r;
    assign res_we    = res_we_r | wb_s;
    assign res_src   = wb_s;
    assign busy      = busy_r;
    assign done      = done_r;

    // Sequencer FSM; outputs are registered together with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            exp_r       <= {WIDTH{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            sel_x_r     <= SEL_ZERO;
            sel_y_r     <= SEL_ZERO;
            mul_start_r <= 1'b0;
            res_we_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            wait_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        exp_r    <= exponent;
                        idx_r    <= IDX_W'(WIDTH - 1);
                        state_r  <= ST_INIT;
                        busy_r   <= 1'b1;
                        sel_x_r  <= SEL_ONE;
                        sel_y_r  <= SEL_ZERO;
                        res_we_r <= 1'b1;
                    end else begin
                        state_r  <= ST_IDLE;
                        busy_r   <= 1'b0;
                        sel_x_r  <= SEL_ZERO;
                        sel_y_r  <= SEL_ZERO;
                        res_we_r <= 1'b0;
                    end
                end
                ST_INIT: begin
                    res_we_r <= 1'b0;
`ifdef RSA_MODEXP_SKIP_LEADING_EN
                    if (exp_r == {WIDTH{1'b0}}) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        sel_x_r <= SEL_ZERO;
                        sel_y_r <= SEL_ZERO;
                    end else begin
                        idx_r       <= msb_index(exp_r);
                        state_r     <= ST_SQR_START;
                        sel_x_r     <= SEL_RES;
                        sel_y_r     <= SEL_RES;
                        mul_start_r <= 1'b1;
                    end
`else
                    state_r     <= ST_SQR_START;
                    sel_x_r     <= SEL_RES;
                    sel_y_r     <= SEL_RES;
                    mul_start_r <= 1'b1;
`endif
                end
                ST_SQR_START: begin
                    mul_start_r <= 1'b0;
                    wait_r      <= 1'b1;
                    state_r     <= ST_SQR_WAIT;
                end
                ST_SQR_WAIT: begin
                    if (mul_done) begin
                        wait_r <= 1'b0;
                        if (exp_r[idx_r]) begin
                            state_r     <= ST_MUL_START;
                            sel_x_r     <= SEL_BASE;
                            sel_y_r     <= SEL_RES;
                            mul_start_r <= 1'b1;
                        end else begin
                            state_r <= ST_NEXT;
                            sel_x_r <= SEL_ZERO;
                            sel_y_r <= SEL_ZERO;
                        end
                    end else begin
                        state_r <= ST_SQR_WAIT;
                    end
                end
                ST_MUL_START: begin
                    mul_start_r <= 1'b0;
                    wait_r      <= 1'b1;
                    state_r     <= ST_MUL_WAIT;
                end
                ST_MUL_WAIT: begin
                    if (mul_done) begin
                        wait_r  <= 1'b0;
                        state_r <= ST_NEXT;
                        sel_x_r <= SEL_ZERO;
                        sel_y_r <= SEL_ZERO;
                    end else begin
                        state_r <= ST_MUL_WAIT;
                    end
                end
                ST_NEXT: begin
                    if (idx_r == {IDX_W{1'b0}}) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        idx_r       <= idx_r - IDX_W'(1);
                        state_r     <= ST_SQR_START;
                        sel_x_r     <= SEL_RES;
                        sel_y_r     <= SEL_RES;
                        mul_start_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    sel_x_r     <= SEL_ZERO;
                    sel_y_r     <= SEL_ZERO;
                    mul_start_r <= 1'b0;
                    res_we_r    <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    wait_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Self-checking bench for rsa_modexp_ctrl (WIDTH = 4). A behavioural
// multiplier and result register close the loop around the controller; the
// final result is compared against base**exp mod m, and the launch sequence,
// write count and done latency against a square-and-multiply reference.

module tb_rsa_modexp_ctrl;

    localparam int W = 4;

`ifdef RSA_MODEXP_SKIP_LEADING_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] exponent;
    logic         mul_done;
    logic [1:0]   sel_x;
    logic [1:0]   sel_y;
    logic         mul_start;
    logic         res_we;
    logic         res_src;
    logic         busy;
    logic         done;

    rsa_modexp_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .exponent  (exponent),
        .mul_done  (mul_done),
        .sel_x     (sel_x),
        .sel_y     (sel_y),
        .mul_start (mul_start),
        .res_we    (res_we),
        .res_src   (res_src),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // environment / observation state
    int  modv = 7;
    int  base = 3;
    int  result = 0;
    int  prod = 0;
    int  lat = 1;
    int  cnt = 0;
    int  spur_mode = 0;   // 0 none, 1 random, 2 every free cycle
    bit  track = 1'b0;
    int  op_cnt = 0;
    int  res_cnt = 0;
    int  done_cnt = 0;
    int  done_cyc = -1;
    bit  busy_c1 = 1'b0;
    bit  busy_at_done = 1'b1;
    int  obs_ops[$];
    int  exp_ops[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int mux_val(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return base;
            2'b10:   return result;
            default: return 0;
        endcase
    endfunction

    // Multiplier model plus result register and output monitor.
    initial begin
        int xv;
        int yv;
        forever begin
            @(negedge clk);
            if (cnt > 0) begin
                cnt--;
                mul_done = (cnt == 0);
            end else begin
                mul_done = (spur_mode == 2) || (spur_mode == 1 && $urandom_range(0, 2) == 0);
            end
            #1;
            if (track) op_cnt++;
            if (track && op_cnt == 1) busy_c1 = busy;
            xv = mux_val(sel_x);
            yv = mux_val(sel_y);
            if (res_we) begin
                res_cnt++;
                result = res_src ? prod : xv;
            end
            if (mul_start) begin
                if (sel_x == 2'b10 && sel_y == 2'b10) obs_ops.push_back(0);
                else if (sel_x == 2'b01 && sel_y == 2'b10) obs_ops.push_back(1);
                else obs_ops.push_back(2);
                prod = (xv * yv) % modv;
                cnt = lat;
            end
            if (done) begin
                done_cnt++;
                done_cyc = op_cnt;
                busy_at_done = busy;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sel_x"}, 32'(sel_x), 32'd3);
        check({tag, "_sel_y"}, 32'(sel_y), 32'd3);
        check({tag, "_strobes"}, {27'd0, mul_start, res_we, res_src, busy, done}, 32'd0);
    endtask

    task automatic run_op(input int e, input int l, input bit disturb, input int spur);
        int top;
        int cyc;
        int r;
        // reference: square-and-multiply from the chosen top bit
        exp_ops.delete();
        top = W - 1;
        if (SKIP) begin
            top = -1;
            for (int b = 0; b < W; b++) if (e[b]) top = b;
        end
        cyc = 2;
        for (int b = top; b >= 0; b--) begin
            exp_ops.push_back(0);
            cyc += l + 2;
            if (e[b]) begin
                exp_ops.push_back(1);
                cyc += l + 1;
            end
        end
        modv = $urandom_range(3, 251);
        base = $urandom_range(0, modv - 1);
        r = 1 % modv;
        for (int i = 0; i < e; i++) r = (r * base) % modv;

        obs_ops.delete();
        res_cnt = 0;
        done_cnt = 0;
        done_cyc = -1;
        busy_c1 = 1'b0;
        busy_at_done = 1'b1;
        result = 32'hDEAD;
        lat = l;

        @(negedge clk);
        start = 1'b1;
        exponent = W'(e);
        @(posedge clk);
        #1;
        op_cnt = 0;
        track = 1'b1;
        spur_mode = spur;
        if (!disturb) start = 1'b0;
        for (int i = 0; i < 600 && done_cnt == 0; i++) begin
            @(negedge clk);
            #2;
            if (disturb) exponent = W'($urandom);
        end
        start = 1'b0;
        track = 1'b0;
        spur_mode = 0;

        check("done_seen", 32'(done_cnt), 32'd1);
        check("done_cycle", 32'(done_cyc), 32'(cyc));
        check("res_we_count", 32'(res_cnt), 32'(1 + exp_ops.size()));
        check("op_count", 32'(obs_ops.size()), 32'(exp_ops.size()));
        for (int i = 0; i < exp_ops.size() && i < obs_ops.size(); i++)
            check("op_kind", 32'(obs_ops[i]), 32'(exp_ops[i]));
        check("result", 32'(result), 32'(r));
        check("busy_cycle1", 32'(busy_c1), 32'd1);
        check("busy_at_done", 32'(busy_at_done), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        exponent = '0;
        mul_done = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // spurious mul_done while idle must be ignored
        res_cnt = 0;
        done_cnt = 0;
        spur_mode = 2;
        repeat (5) @(negedge clk);
        #2;
        spur_mode = 0;
        check("idle_spur_res_we", 32'(res_cnt), 32'd0);
        check("idle_spur_busy", 32'(busy), 32'd0);
        check("idle_spur_done", 32'(done_cnt), 32'd0);

        run_op(4'b1011, 3, 1'b0, 0);
        check("cycle34", 32'(done_cyc), 32'd34);
        run_op(0, 3, 1'b0, 0);
        check("exp0_cycle", 32'(done_cyc), SKIP ? 32'd2 : 32'd22);
        run_op(4'b0101, 1, 1'b0, 0);
        run_op(1, 2, 1'b0, 1);
        run_op(4'b1111, 4, 1'b0, 1);
        run_op(4'b1011, 3, 1'b1, 0);

        // reset during MUL_WAIT (cycles 7..9 for exponent 1111, L = 3)
        modv = 11;
        base = 5;
        lat = 3;
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        exponent = 4'b1111;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_cnt = 0;
        track = 1'b1;
        for (int i = 0; i < 100 && op_cnt < 8; i++) begin
            @(negedge clk);
            #2;
        end
        check("reached_mul_wait", 32'(op_cnt), 32'd8);
        rst_n = 1'b0;
        cnt = 0;
        mul_done = 1'b0;
        track = 1'b0;
        #1;
        check_reset_outputs("midop_reset");
        repeat (2) @(negedge clk);
        #2;
        check("no_done_on_reset", 32'(done_cnt), 32'd0);
        rst_n = 1'b1;
        run_op(4'b1111, 3, 1'b0, 0);

        for (int k = 0; k < 15; k++)
            run_op($urandom_range(0, 15), $urandom_range(1, 4), 1'($urandom_range(0, 1)), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
